// File: rtl/alu_pkg.sv
// Shared opcode encoding and FSM state type for the sequential ALU.
// is_iter_op() marks the opcodes that take the multi-cycle datapath.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_SL   = 4'b0010,
        OP_AND  = 4'b0011,
        OP_SR   = 4'b0100,
        OP_BLT  = 4'b0101,
        OP_OR   = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_MUL  = 4'b1000,
        OP_BGT  = 4'b1001,
        OP_DIVU = 4'b1010,
        OP_REMU = 4'b1011,
        OP_BEQ  = 4'b1100,
        OP_XOR  = 4'b1101
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per cycle.
// o_done/o_result are valid in the last busy cycle; o_result is the post-step value.
module alu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CW   = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    logic            r_busy;
    logic [CW-1:0]   r_cnt;
    logic            r_is_mul;
    logic            r_is_rem;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_x;
    logic [XLEN-1:0] r_y;

    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_fits;
    logic [XLEN-1:0] w_acc_nx;
    logic [XLEN-1:0] w_x_nx;
    logic [XLEN-1:0] w_y_nx;

    // MUL: acc += x when y[0]; x shifts left, y right. DIV: x holds dividend/quotient, y divisor.
    always_comb begin
        w_rem_sh = {r_acc, r_x[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, r_y};
        w_fits   = !w_diff[XLEN];
        w_acc_nx = r_acc;
        w_x_nx   = r_x;
        w_y_nx   = r_y;
        if (r_is_mul) begin
            w_acc_nx = r_y[0] ? (r_acc + r_x) : r_acc;
            w_x_nx   = {r_x[XLEN-2:0], 1'b0};
            w_y_nx   = {1'b0, r_y[XLEN-1:1]};
        end else begin
            w_acc_nx = w_fits ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
            w_x_nx   = {r_x[XLEN-2:0], w_fits};
            w_y_nx   = r_y;
        end
    end

    assign o_done   = r_busy && (r_cnt == {CW{1'b0}});
    assign o_result = (r_is_mul || r_is_rem) ? w_acc_nx : w_x_nx;

    // Operand capture on start, then one iteration per busy cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= {CW{1'b0}};
            r_is_mul <= 1'b0;
            r_is_rem <= 1'b0;
            r_acc    <= {XLEN{1'b0}};
            r_x      <= {XLEN{1'b0}};
            r_y      <= {XLEN{1'b0}};
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= CW'(XLEN - 1);
            r_is_mul <= (i_op == OP_MUL);
            r_is_rem <= (i_op == OP_REMU);
            r_acc    <= {XLEN{1'b0}};
            r_x      <= i_a;
            r_y      <= i_b;
        end else if (r_busy) begin
            r_acc <= w_acc_nx;
            r_x   <= w_x_nx;
            r_y   <= w_y_nx;
            if (r_cnt == {CW{1'b0}}) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops finish in one cycle,
// MUL/DIVU/REMU run through alu_iter and return XLEN+1 cycles after acceptance.
module seq_alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch
);

    state_e          r_state;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_branch;

    logic            w_accept;
    logic            w_iter_op;
    logic            w_iter_done;
    logic [XLEN-1:0] w_iter_result;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_res;
    logic            w_br;

    assign in_ready  = !rst && (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_iter_op = is_iter_op(alu_op);
    assign w_shamt   = b[SHW-1:0];

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign branch    = r_branch;

    alu_iter #(.XLEN(XLEN)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept && w_iter_op),
        .i_op     (alu_op),
        .i_a      (a),
        .i_b      (b),
        .o_done   (w_iter_done),
        .o_result (w_iter_result)
    );

    // Single-cycle result; compares return zero data, unknown codes fall back to ADD.
    always_comb begin
        w_res = a + b;
        w_br  = 1'b0;
        case (alu_op)
            OP_ADD:  w_res = a + b;
            OP_SUB:  w_res = a - b;
            OP_SL:   w_res = a << w_shamt;
            OP_AND:  w_res = a & b;
            OP_SR:   w_res = a >> w_shamt;
            OP_OR:   w_res = a | b;
            OP_SRA:  w_res = XLEN'($signed(a) >>> w_shamt);
            OP_XOR:  w_res = a ^ b;
            OP_BLT:  begin w_res = {XLEN{1'b0}}; w_br = (a < b);  end
            OP_BGT:  begin w_res = {XLEN{1'b0}}; w_br = (a > b);  end
            OP_BEQ:  begin w_res = {XLEN{1'b0}}; w_br = (a == b); end
            default: w_res = a + b;
        endcase
    end

    // Control FSM and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= {XLEN{1'b0}};
            r_branch    <= 1'b0;
        end else if (w_accept && !w_iter_op) begin
            r_result    <= w_res;
            r_branch    <= w_br;
            r_out_valid <= 1'b1;
        end else if (w_accept) begin
            r_state     <= BUSY;
            r_out_valid <= 1'b0;
        end else if ((r_state == BUSY) && w_iter_done) begin
            r_state     <= IDLE;
            r_result    <= w_iter_result;
            r_branch    <= 1'b0;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (XLEN = 32): directed corner cases, a back-to-back
// burst, reset during MUL, then randomized ops against an arithmetic reference model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        branch;

    int n_checks = 0;
    int n_pass   = 0;

    seq_alu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .branch    (branch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_model(input logic [3:0] op, input logic [31:0] x,
                                      input logic [31:0] y, output logic [31:0] r,
                                      output logic br);
        logic [63:0] wide;
        int unsigned sh;
        sh = y % 32;
        r  = 32'd0;
        br = 1'b0;
        case (op)
            4'd1:  r = x - y;
            4'd2:  r = x << sh;
            4'd3:  r = x & y;
            4'd4:  r = x >> sh;
            4'd5:  br = (x < y);
            4'd6:  r = x | y;
            4'd7:  begin wide = {{32{x[31]}}, x} >> sh; r = wide[31:0]; end
            4'd8:  begin wide = 64'(x) * 64'(y); r = wide[31:0]; end
            4'd9:  br = (x > y);
            4'd10: r = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            4'd11: r = (y == 32'd0) ? x : x % y;
            4'd12: br = (x == y);
            4'd13: r = x ^ y;
            default: r = x + y;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int stall, input string tag);
        logic [31:0] er;
        logic        ebr;
        int          lat;
        int          n;
        bit          busy_ok;
        bit          hold_ok;
        logic [31:0] held;
        ref_model(op, x, y, er, ebr);
        lat = (op == 4'd8 || op == 4'd10 || op == 4'd11) ? 33 : 1;
        out_ready = (stall == 0);
        alu_op = op; a = x; b = y; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        check({tag, " accept"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        n = 1;
        busy_ok = 1'b1;
        // Junk requests while busy must be ignored.
        while (!out_valid && n < 100) begin
            if (in_ready) busy_ok = 1'b0;
            in_valid = (n < 20);
            a = $urandom; b = $urandom; alu_op = 4'($urandom);
            tick();
            n++;
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 64'(n), 64'(lat));
        if (lat > 1) check({tag, " busy_ready"}, 64'(busy_ok), 64'd1);
        check({tag, " result"}, 64'(result), 64'(er));
        check({tag, " branch"}, 64'(branch), 64'(ebr));
        if (stall > 0) begin
            hold_ok = 1'b1;
            held = result;
            for (int s = 0; s < stall; s++) begin
                if (in_ready || !out_valid || result !== held || branch !== ebr) hold_ok = 1'b0;
                tick();
            end
            check({tag, " hold"}, 64'(hold_ok), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        check({tag, " drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] er;
        logic        ebr;
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  op;
        logic [3:0]  burst_ops [4];
        bit          ghost;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 32'd0; b = 32'd0; alu_op = 4'd0;
        repeat (2) tick();
        check("rst in_ready", 64'(in_ready), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst result", 64'(result), 64'd0);
        check("rst branch", 64'(branch), 64'd0);
        rst = 1'b0;
        #1;
        check("idle in_ready", 64'(in_ready), 64'd1);

        run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 0, "add_wrap");
        run_op(4'd7, 32'h8000_0000, 32'h0000_0024, 0, "sra");
        run_op(4'd8, 32'h0001_0003, 32'h0002_0005, 0, "mul");
        run_op(4'd10, 32'd100, 32'd0, 0, "divu_zero");
        run_op(4'd11, 32'd100, 32'd7, 0, "remu");
        run_op(4'd11, 32'd100, 32'd0, 0, "remu_zero");
        run_op(4'd5, 32'd1, 32'hFFFF_FFFF, 5, "blt_stall");
        run_op(4'd15, 32'd5, 32'd6, 0, "undef_add");

        // Back-to-back single-cycle ops at full throughput.
        burst_ops[0] = 4'd0; burst_ops[1] = 4'd1; burst_ops[2] = 4'd13; burst_ops[3] = 4'd12;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x = $urandom; y = (i == 3) ? x : $urandom;
            ref_model(burst_ops[i], x, y, er, ebr);
            alu_op = burst_ops[i]; a = x; b = y; in_valid = 1'b1;
            check("burst ready", 64'(in_ready), 64'd1);
            tick();
            check("burst valid", 64'(out_valid), 64'd1);
            check("burst result", 64'(result), 64'(er));
            check("burst branch", 64'(branch), 64'(ebr));
        end
        in_valid = 1'b0;
        tick();
        check("burst drop", 64'(out_valid), 64'd0);

        // Reset ten cycles into a MUL must abort it silently.
        alu_op = 4'd8; a = 32'h1234_5678; b = 32'h0000_0101; in_valid = 1'b1;
        check("abort accept", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        #1;
        check("abort rst in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort result", 64'(result), 64'd0);
        check("abort idle", 64'(in_ready), 64'd1);
        ghost = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid) ghost = 1'b1;
        end
        check("abort no_result", 64'(ghost), 64'd0);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op(op, x, y, $urandom_range(0, 2), $sformatf("rand%0d_op%0d", i, op));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
